lix_shr_arb: RTL

LIX_SHR_ARB -- requirements
Module: lix_shr_arb

---
 rtl/lix_shr_pkg.sv | 12 +
 rtl/lix_rr_arb.sv | 21 ++
 rtl/lix_vreg.sv | 18 +
 rtl/lix_shr_arb.sv | 70 +++++++
 4 files changed

// File: rtl/lix_shr_pkg.sv
// lix_shr_pkg: shared constants and clog2 helper for the lix_shr_arb slice
package lix_shr_pkg;
  localparam int LIX_W = 32;
  localparam int LIX_N = 2;
  localparam int LIX_R = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/lix_rr_arb.sv
// lix_rr_arb: one-hot arbiter searching upward from ptr; LIX_SHR_ARB_PRIO_EN forces fixed priority from 0
module lix_rr_arb import lix_shr_pkg::*; #(
  parameter int R  = LIX_R,
  parameter int IW = clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  gnt
);
  logic [IW-1:0] base;
  logic [R-1:0] rot, rg;
`ifdef LIX_SHR_ARB_PRIO_EN
  assign base = '0;
`else
  assign base = ptr;
`endif
  // rotate so base sits at bit 0, take the lowest set bit, rotate back
  assign rot = R'({req, req} >> base);
  assign rg  = rot & -rot;
  assign gnt = R'(({rg, rg} << base) >> R);
endmodule

// File: rtl/lix_vreg.sv
// lix_vreg: enable-gated register cell with synchronous clear
module lix_vreg #(
  parameter int WD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] q
);
  logic [WD-1:0] q_d, q_q;
  always_comb q_d = en ? d : q_q;
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/lix_shr_arb.sv
// lix_shr_arb: arbitrates R requesters into an N-stage valid pipeline; LIX_SHR_ARB_PRIO_EN selects fixed priority
module lix_shr_arb import lix_shr_pkg::*; #(
  parameter int W  = LIX_W,
  parameter int N  = LIX_N,
  parameter int R  = LIX_R,
  parameter int IW = clog2(R)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_en,
  input  logic                    i_flush,
  input  logic [R-1:0]            i_req,
  input  logic [R*W-1:0]          i_dat,
  output logic [R-1:0]            o_gnt,
  output logic                    o_vld,
  output logic [IW-1:0]           o_id,
  output logic [W-1:0]            o_z,
  output logic [clog2(N+1)-1:0]   o_cnt
);
  localparam int CW = clog2(N+1);
  logic go, gnt_any;
  logic [IW-1:0] p_q, p_d, gnt_id;
  logic [W-1:0] dat_sel;
  logic [N-1:0] v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW+W-1:0] sd [N];
  assign go = i_en & ~i_flush & ~rst_i;
  lix_rr_arb #(.R(R), .IW(IW)) u_arb (.req(i_req & {R{go}}), .ptr(p_q), .gnt(o_gnt));
  assign gnt_any = |o_gnt;
  always_comb begin
    gnt_id = '0;
    dat_sel = '0;
    for (int i = 0; i < R; i++) if (o_gnt[i]) begin
      gnt_id = IW'(i);
      dat_sel = i_dat[i*W +: W];
    end
  end
  always_comb begin
    p_d = gnt_any ? ((gnt_id == IW'(R-1)) ? '0 : gnt_id + 1'b1) : p_q;
    v_d = i_flush ? '0 : i_en ? N'({v_q, gnt_any}) : v_q;
    cnt_d = i_flush ? '0 : cnt_q + CW'(gnt_any) - CW'(o_vld & i_en);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q <= '0;
      v_q <= '0;
      cnt_q <= '0;
    end else begin
      p_q <= p_d;
      v_q <= v_d;
      cnt_q <= cnt_d;
    end
  end
  // id/data only move behind a valid item, so idle cycles leave them untouched
  for (genvar s = 0; s < N; s++) begin : g_stg
    logic en_s;
    logic [IW+W-1:0] d_s;
    if (s == 0) begin : g_in
      assign en_s = i_en & ~i_flush & gnt_any;
      assign d_s = {gnt_id, dat_sel};
    end else begin : g_sh
      assign en_s = i_en & ~i_flush & v_q[s-1];
      assign d_s = sd[s-1];
    end
    lix_vreg #(.WD(IW+W)) u_reg (.clk(clk_i), .rst(rst_i), .en(en_s), .d(d_s), .q(sd[s]));
  end
  assign o_vld = v_q[N-1];
  assign {o_id, o_z} = sd[N-1];
  assign o_cnt = cnt_q;
endmodule
